priority_decoder_accum: RTL and testbench

//   Inverse of the priority encoder. Receives a stream of encoded indices
//   (highest set bit first, as produced by iterating the encoder and clearing
//   the reported bit) and rebuilds the original N-bit request vector.

---
 rtl/priority_decoder_accum.sv | 143 ++++++++++++++
 tb/tb_priority_decoder_accum.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder_accum.sv
// rtl/priority_decoder_accum.sv - rebuilds a request vector from a stream of priority-encoded indices
//
// Purpose:
//   Receive side of the encoded request link. Each accepted beat carries one
//   bit index (highest first) or an explicit "no bit" marker; the frame is
//   OR-ed back into an N-bit mask and reported with a beat count and an
//   ordering-error flag.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_idx     - encoded bit index
//   in_zero    - beat carries no bit (empty request vector)
//   in_last    - final beat of the frame
//   in_valid   - input beat present
//   in_ready   - block accepts a beat (low while a result is held)
//   out_mask   - rebuilt vector
//   out_count  - number of bit-carrying beats in the frame (saturates at N)
//   out_err    - frame broke the ordering rules
//   out_valid  - out_* fields valid
//   out_ready  - downstream accepts result
module priority_decoder_accum #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_idx,
  input  logic         in_zero,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_mask,
  output logic [W:0]   out_count,
  output logic         out_err,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W:0]   COUNT_MAX = (W+1)'(N);

  state_t       state_q;
  logic [N-1:0] mask_q, mask_d;
  logic [W:0]   count_q, count_d;
  logic         err_q, err_d;
  logic [W-1:0] prev_q, prev_d;
  logic [N-1:0] out_mask_q;
  logic [W:0]   out_count_q;
  logic         out_err_q;
  logic         out_valid_q;
  logic         in_ready_q;

  // Accumulator update assuming the current beat is accepted.
  always_comb begin
    mask_d  = mask_q;
    count_d = count_q;
    err_d   = err_q;
    prev_d  = prev_q;
    if (in_zero) begin
      // An empty marker is only legal as the one and only beat of a frame.
      if (!(state_q == IDLE && in_last)) begin
        err_d = 1'b1;
      end
    end else begin
      mask_d = mask_q | (ONE_HOT0 << in_idx);
      // count_q != 0 means a previous bit-carrying beat exists in this frame.
      if (count_q != '0 && in_idx >= prev_q) begin
        err_d = 1'b1;
      end
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 1'b1;
      end
      prev_d = in_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      prev_q      <= '0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (in_valid) begin
            if (in_last) begin
              // Publish the frame and clear accumulators for the next one.
              out_mask_q  <= mask_d;
              out_count_q <= count_d;
              out_err_q   <= err_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              mask_q      <= '0;
              count_q     <= '0;
              err_q       <= 1'b0;
              prev_q      <= '0;
              state_q     <= OUTPUT;
            end else begin
              mask_q  <= mask_d;
              count_q <= count_d;
              err_q   <= err_d;
              prev_q  <= prev_d;
              state_q <= COLLECT;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_priority_decoder_accum.sv
// tb/tb_priority_decoder_accum.sv - directed self-checking bench for priority_decoder_accum
module tb_priority_decoder_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_idx;
  logic       in_zero;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_err = 0;

  priority_decoder_accum #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_idx    (in_idx),
    .in_zero   (in_zero),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; in_ready must be high when it is offered.
  task automatic beat(input logic [2:0] idx, input logic zero, input logic last);
    check("beat_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_idx   = idx;
    in_zero  = zero;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_idx   = 3'd0;
    in_zero  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] m, input logic [3:0] c, input logic e);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_mask"},  {24'd0, out_mask},  {24'd0, m});
    check({tag, "_count"}, {28'd0, out_count}, {28'd0, c});
    check({tag, "_err"},   {31'd0, out_err},   {31'd0, e});
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  logic [2:0] s_idx  [6] = '{3'd6, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1};
  logic       s_last [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] f_mask [3] = '{8'h44, 8'h20, 8'h92};
  logic [3:0] f_cnt  [3] = '{4'd2, 4'd1, 4'd3};

  initial begin
    int k;
    int f;
    int cyc;
    int bubbles;
    logic rdy;

    rst = 1'b1; in_idx = '0; in_zero = 1'b0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mask",  {24'd0, out_mask},  32'd0);
    check("rst_count", {28'd0, out_count}, 32'd0);
    check("rst_err",   {31'd0, out_err},   32'd0);
    check("rst_ready", {31'd0, in_ready},  32'd1);

    // Reset in the middle of a frame discards the partial beats.
    beat(3'd5, 1'b0, 1'b0);
    beat(3'd3, 1'b0, 1'b0);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_mask",  {24'd0, out_mask},  32'd0);
    check("midrst_ready", {31'd0, in_ready},  32'd1);
    beat(3'd6, 1'b0, 1'b1);
    expect_result("after_rst", 8'h40, 4'd1, 1'b0);
    release_out("after_rst");

    beat(3'd0, 1'b0, 1'b1);
    expect_result("single0", 8'h01, 4'd1, 1'b0);
    release_out("single0");

    // Result must hold while downstream stalls.
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd5, 1'b0, 1'b0);
    beat(3'd2, 1'b0, 1'b1);
    expect_result("f752", 8'hA4, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_result("f752_stall", 8'hA4, 4'd3, 1'b0);
    end
    release_out("f752");

    beat(3'd0, 1'b1, 1'b1);
    expect_result("empty", 8'h00, 4'd0, 1'b0);
    release_out("empty");

    beat(3'd4, 1'b0, 1'b0);
    beat(3'd0, 1'b1, 1'b1);
    expect_result("zero2nd", 8'h10, 4'd1, 1'b1);
    release_out("zero2nd");

    beat(3'd3, 1'b0, 1'b0);
    beat(3'd3, 1'b0, 1'b0);
    beat(3'd6, 1'b0, 1'b1);
    expect_result("order_err", 8'h48, 4'd3, 1'b1);
    release_out("order_err");

    for (int i = 7; i >= 0; i--) begin
      beat(3'(i), 1'b0, (i == 0));
    end
    expect_result("full8", 8'hFF, 4'd8, 1'b0);
    release_out("full8");

    // Back-to-back frames with both sides always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    k = 0; f = 0; cyc = 0; bubbles = 0;
    while (k < 6 && cyc < 50) begin
      in_idx  = s_idx[k];
      in_zero = 1'b0;
      in_last = s_last[k];
      rdy     = in_ready;
      tick();
      cyc++;
      if (rdy) k++;
      else bubbles++;
      if (out_valid) begin
        if (f < 3) begin
          check("b2b_mask",  {24'd0, out_mask},  {24'd0, f_mask[f]});
          check("b2b_count", {28'd0, out_count}, {28'd0, f_cnt[f]});
          check("b2b_err",   {31'd0, out_err},   32'd0);
        end
        f++;
      end
    end
    in_valid = 1'b0;
    check("b2b_beats",   k,       6);
    check("b2b_frames",  f,       3);
    check("b2b_bubbles", bubbles, 2);
    check("b2b_cycles",  cyc,     8);
    tick();
    out_ready = 1'b0;
    check("b2b_end_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
